sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of storage entries (SHALL be >= 2; need not be a power of two).
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 write  input  1  push request; write_data is captured when accepted.
REQ-006 read  input  1  pop request.
REQ-007 write_data  input  WIDTH  data to push.
REQ-008 read_data  output  WIDTH  registered data of the most recently popped entry.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when zero entries are stored.

Function
REQ-011 Storage SHALL be an array of DEPTH words of WIDTH bits, with a write pointer, a read pointer and an occupancy count of width clog2(DEPTH+1).
REQ-012 A write SHALL be accepted when write=1 and full=0; the word goes to mem[wr_ptr] and wr_ptr advances by one.
REQ-013 A read SHALL be accepted when read=1 and empty=0; read_data <= mem[rd_ptr] at that edge (one-cycle latency) and rd_ptr advances by one.
REQ-014 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-015 read_data SHALL hold its last value when no read is accepted.
REQ-016 A write while full SHALL be ignored; no state change and no overwrite, even if read=1 in the same cycle.
REQ-017 A read while empty SHALL be ignored, and read_data holds its value.
REQ-018 A simultaneous accepted read and write SHALL both occur, leaving count unchanged.
REQ-019 A simultaneous read and write while empty SHALL accept only the write, giving count 1.
REQ-020 Count SHALL be +1 on write-only, -1 on read-only, and unchanged otherwise.
REQ-021 full = (count == DEPTH) and empty = (count == 0), decoded combinationally from registered count.
REQ-022 Data SHALL leave in exactly the order it was accepted.

Reset
REQ-023 While reset=0, wr_ptr, rd_ptr, count and read_data SHALL be 0 immediately, independent of clk.
REQ-024 During reset, empty=1 and full=0.
REQ-025 Memory contents need not be cleared.
REQ-026 Reset mid-operation SHALL discard all stored entries.
REQ-027 The first accepted operation SHALL be on the first rising edge after reset deasserts.

Structure
REQ-028 Single module with no sub-modules.
REQ-029 No shared package is required.
REQ-030 Pointer and count widths SHALL be local parameters derived from DEPTH.

Verification
REQ-031 Reset, then idle -> empty=1, full=0, read_data=0x00.
REQ-032 Write 0x70 then 0x71, then read one cycle -> read_data=0x70 after that edge; empty=0 (one entry left).
REQ-033 Continuing REQ-032: write 0x72, then read -> read_data=0x71; then read again -> read_data=0x72 and empty=1.
REQ-034 Write 8 words 0x00..0x07 -> full=1; a ninth write of 0xFF is ignored; 8 reads return 0x00..0x07 in order, then empty=1.
REQ-035 Read while empty -> read_data unchanged and pointers unchanged; simultaneous read+write while empty -> count=1 and read_data unchanged.
REQ-036 Fill with 3 entries, assert reset asynchronously between edges -> empty=1 and read_data=0 immediately; a subsequent read is ignored.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers for the synchronous FIFO
package sync_fifo_pkg;

  // Pointer width for a DEPTH-entry array. It never drops below 1 bit,
  // so a degenerate depth still yields a legal vector.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width. It must represent every value from 0 to DEPTH inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   write      : push request, accepted when not full
//   read       : pop request, accepted when not empty
//   write_data : word to push
//   read_data  : registered word from the most recent accepted pop
//   full       : DEPTH entries stored
//   empty      : no entries stored
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic wr_en;
  logic rd_en;

  // Acceptance is decided from the registered count only. A write while
  // full is therefore refused even if a read frees a slot on the same edge.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = write & ~full;
  assign rd_en = read & ~empty;

  // Storage carries no reset. Stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      read_data <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue model
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic             full;
  logic             empty;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_rd;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .read       (read),
    .write_data (write_data),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus. The model applies the FIFO rules to the state
  // before the edge: a pop happens only if something is stored, and a push
  // happens only if the FIFO is not full. Outputs are sampled 1 ns after the edge.
  task automatic do_cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit can_wr;
    bit can_rd;
    @(negedge clk);
    write      = w;
    read       = r;
    write_data = d;
    can_wr = w && (model_q.size() < DEPTH);
    can_rd = r && (model_q.size() > 0);
    @(posedge clk);
    if (can_rd) exp_rd = model_q.pop_front();
    if (can_wr) model_q.push_back(d);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    exp_rd = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b expected empty=1 full=0", empty, full);
    end
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    exp_rd = '0;
    do_cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: empty=%b full=%b read_data=%h expected 1 0 00", empty, full, read_data);
    end
  endtask

  task automatic test_basic();
    do_cycle(1'b1, 1'b0, 8'h70);
    do_cycle(1'b1, 1'b0, 8'h71);
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'h70 || read_data !== exp_rd || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_pop: read_data=%h empty=%b expected 70 0", read_data, empty);
    end
    do_cycle(1'b1, 1'b0, 8'h72);
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'h71 || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_second_pop: read_data=%h empty=%b expected 71 0", read_data, empty);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'h72 || empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_third_pop: read_data=%h empty=%b expected 72 1", read_data, empty);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] last;
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, WIDTH'(i));
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: full=%b empty=%b expected 1 0", full, empty);
    end
    do_cycle(1'b1, 1'b0, 8'hFF);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_overflow_flag: full=%b expected 1", full);
    end
    // A write together with a read while full must not push. Only the pop is accepted.
    last = read_data;
    do_cycle(1'b1, 1'b1, 8'hEE);
    checks++;
    if (read_data !== 8'h00 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: read_data=%h full=%b expected 00 0 (prev %h)", read_data, full, last);
    end
    for (int i = 1; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (read_data !== WIDTH'(i) || read_data !== exp_rd) begin
        errors++;
        $display("FAIL full_drain_%0d: read_data=%h expected %h", i, read_data, WIDTH'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: empty=%b full=%b expected 1 0", empty, full);
    end
  endtask

  task automatic test_empty();
    logic [WIDTH-1:0] held;
    held = read_data;
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== held || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_read: read_data=%h empty=%b expected %h 1", read_data, empty, held);
    end
    do_cycle(1'b1, 1'b1, 8'h5A);
    checks++;
    if (read_data !== held || empty !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: read_data=%h empty=%b full=%b expected %h 0 0", read_data, empty, full, held);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'h5A || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_pop: read_data=%h empty=%b expected 5a 1", read_data, empty);
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1'b1, 1'b0, 8'hA1);
    do_cycle(1'b1, 1'b0, 8'hA2);
    do_cycle(1'b1, 1'b0, 8'hA3);
    do_cycle(1'b1, 1'b0, 8'hA4);
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'hA1) begin
      errors++;
      $display("FAIL areset_pre: read_data=%h expected a1", read_data);
    end
    // Assert reset mid-cycle, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || read_data !== 8'h00) begin
      errors++;
      $display("FAIL areset_immediate: empty=%b full=%b read_data=%h expected 1 0 00", empty, full, read_data);
    end
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    exp_rd = '0;
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (read_data !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL areset_read_ignored: read_data=%h empty=%b expected 00 1", read_data, empty);
    end
  endtask

  task automatic test_random();
    int wr_pct;
    logic w;
    logic r;
    for (int n = 0; n < 400; n++) begin
      // Sweep the write bias so the run reaches both full and empty repeatedly.
      wr_pct = ((n / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wr_pct);
      r = ($urandom_range(0, 99) < (100 - wr_pct));
      do_cycle(w, r, WIDTH'($urandom));
      checks++;
      if (read_data !== exp_rd || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
        errors++;
        $display("FAIL random_%0d: read_data=%h full=%b empty=%b expected %h %b %b", n, read_data, full, empty,
                 exp_rd, model_q.size() == DEPTH, model_q.size() == 0);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    write_data = '0;
    exp_rd     = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_full();
    test_empty();
    test_async_reset();
    apply_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
